hero_write_rx: RTL and testbench

Consumes the hero write bus (hero_write_t beats tagged IDLE/VALID/DONE) immediately downstream of the hero bus driver. Buffers each transaction store-and-forward in a beat FIFO and commits it only when its DONE beat arrives. Presents committed beats on a valid/ready stream with a last flag. The hero bus has no backpressure, so a transaction that cannot fit is dropped whole and counted.

---
 rtl/hero_write_rx.sv | 117 +++++++++++
 tb/tb_hero_write_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hero_write_rx.sv
// hero_write_rx: store-and-forward hero write bus receiver with whole-transaction drop on overflow
// Optional txn_cnt output enabled by defining HERO_WRITE_RX_STATS_EN
module hero_write_rx #(
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [45:0]          hero_wr_i,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [35:0]          out_wdat,
    output logic [6:0]           out_sub,
    output logic                 out_last,
    output logic                 drop_pulse,
    output logic                 proto_err,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic                 idle
`ifdef HERO_WRITE_RX_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] txn_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PONE = (AW+1)'(1);
    localparam logic [AW:0] PDEPTH = (AW+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CONE = CNT_WIDTH'(1);
    localparam logic [1:0] RX_IDLE = 2'd0, RX_ACTIVE = 2'd1, RX_DROP = 2'd2;
    localparam logic [1:0] T_IDLE = 2'd0, T_DONE = 2'd2, T_ILL = 2'd3;

    logic [1:0]  cyc;
    logic [35:0] wdat;
    logic [6:0]  sub;
    logic        en;
    assign {cyc, wdat, sub, en} = hero_wr_i;

    logic [43:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [1:0]  state_q, state_d;
    logic        we, last, drop_d, proto_d, full, pop;

    assign full    = (wr_q - rd_q) == PDEPTH;
    assign out_vld = rd_q != cm_q;
    assign pop     = out_vld && out_rdy;
    assign {out_wdat, out_sub, out_last} = mem_q[rd_q[AW-1:0]];
    assign idle    = (state_q == RX_IDLE) && (wr_q == rd_q);

    // receive FSM: decide write, commit, discard and error for the sampled beat
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        cm_d    = cm_q;
        we      = 1'b0;
        last    = 1'b0;
        drop_d  = 1'b0;
        proto_d = 1'b0;
        rd_d    = pop ? rd_q + PONE : rd_q;
        if (en) begin
            if (cyc == T_ILL) begin
                proto_d = 1'b1;
                state_d = RX_IDLE;
                if (state_q == RX_ACTIVE) begin
                    wr_d   = cm_q;
                    drop_d = 1'b1;
                end
            end else if (cyc != T_IDLE) begin
                if (state_q == RX_DROP) begin
                    state_d = (cyc == T_DONE) ? RX_IDLE : RX_DROP;
                end else if (full) begin
                    wr_d    = cm_q;
                    drop_d  = 1'b1;
                    state_d = (cyc == T_DONE) ? RX_IDLE : RX_DROP;
                end else begin
                    we      = 1'b1;
                    last    = cyc == T_DONE;
                    wr_d    = wr_q + PONE;
                    cm_d    = last ? wr_q + PONE : cm_q;
                    state_d = last ? RX_IDLE : RX_ACTIVE;
                end
            end
        end
    end

    // beat storage; contents are meaningless until covered by commit_ptr
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_q[AW-1:0]] <= {wdat, sub, last};
    end

    // pointers, FSM state, status pulses and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            cm_q       <= '0;
            rd_q       <= '0;
            state_q    <= RX_IDLE;
            drop_pulse <= 1'b0;
            proto_err  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            wr_q       <= wr_d;
            cm_q       <= cm_d;
            rd_q       <= rd_d;
            state_q    <= state_d;
            drop_pulse <= drop_d;
            proto_err  <= proto_d;
            if (drop_d && !(&drop_cnt)) drop_cnt <= drop_cnt + CONE;
        end
    end

`ifdef HERO_WRITE_RX_STATS_EN
    // saturating count of fully delivered transactions
    always_ff @(posedge clk) begin
        if (rst) txn_cnt <= '0;
        else if (pop && out_last && !(&txn_cnt)) txn_cnt <= txn_cnt + CONE;
    end
`endif
endmodule

// File: tb/tb_hero_write_rx.sv
// tb_hero_write_rx: scoreboard bench for hero_write_rx (DEPTH=4, CNT_WIDTH=2 to reach overflow and saturation)
module tb_hero_write_rx;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int CMAX  = 3;

    typedef struct packed {
        logic [35:0] d;
        logic [6:0]  s;
        logic        l;
    } beat_t;

    logic          clk = 0;
    logic          rst = 1;
    logic [45:0]   hero_wr_i = '0;
    logic          out_vld, out_rdy = 0, out_last, drop_pulse, proto_err, idle;
    logic [35:0]   out_wdat;
    logic [6:0]    out_sub;
    logic [CW-1:0] drop_cnt;
`ifdef HERO_WRITE_RX_STATS_EN
    logic [CW-1:0] txn_cnt;
`endif

    hero_write_rx #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .hero_wr_i(hero_wr_i),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_wdat(out_wdat), .out_sub(out_sub),
        .out_last(out_last), .drop_pulse(drop_pulse), .proto_err(proto_err),
        .drop_cnt(drop_cnt), .idle(idle)
`ifdef HERO_WRITE_RX_STATS_EN
        , .txn_cnt(txn_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    n_chk = 0, n_pass = 0;
    beat_t sb[$];
    beat_t pend[$];
    int    ms = 0;
    int    mcnt = 0, mt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // drive one bus cycle, advance the reference model, check status one cycle later
    task automatic send(input logic [1:0] t, input logic [35:0] d, input logic [6:0] s,
                        input logic e, input logic rdy);
        logic xd, xp;
        int   occ;
        xd = 0;
        xp = 0;
        occ = sb.size() + pend.size();
        hero_wr_i = {t, d, s, e};
        out_rdy = rdy;
        if (e) begin
            if (t == 2'd3) begin
                xp = 1;
                if (ms == 1) begin
                    xd = 1;
                    pend.delete();
                end
                ms = 0;
            end else if (t != 2'd0) begin
                if (ms == 2) begin
                    if (t == 2'd2) ms = 0;
                end else if (occ == DEPTH) begin
                    xd = 1;
                    pend.delete();
                    ms = (t == 2'd2) ? 0 : 2;
                end else begin
                    pend.push_back('{d, s, t == 2'd2});
                    if (t == 2'd2) begin
                        foreach (pend[i]) sb.push_back(pend[i]);
                        pend.delete();
                        ms = 0;
                    end else ms = 1;
                end
            end
        end
        if (xd && mcnt != CMAX) mcnt++;
        @(posedge clk);
        #1;
        chk("drop_pulse", drop_pulse, xd);
        chk("proto_err", proto_err, xp);
        chk("drop_cnt", drop_cnt, mcnt);
    endtask

    task automatic tick(input logic rdy);
        send(2'd0, 36'h0, 7'h0, 1'b1, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1'b1);
        chk("drain_empty", sb.size(), 0);
        chk("idle", idle, (ms == 0 && pend.size() == 0));
        chk("out_vld_drained", out_vld, 0);
    endtask

    task automatic do_reset();
        out_rdy = 0;
        hero_wr_i = '0;
        rst = 1;
        sb.delete();
        pend.delete();
        ms = 0;
        mcnt = 0;
        mt = 0;
        @(posedge clk);
        #1;
        rst = 0;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_idle", idle, 1);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        chk("rst_proto_err", proto_err, 0);
    endtask

    // output monitor: every accepted beat must match the head of the scoreboard
    always @(negedge clk) begin
        beat_t b;
        if (!rst && out_vld && out_rdy) begin
            if (sb.size() == 0) chk("spurious_beat", 1, 0);
            else begin
                b = sb.pop_front();
                chk("out_wdat", out_wdat, b.d);
                chk("out_sub", out_sub, b.s);
                chk("out_last", out_last, b.l);
                if (b.l && mt != CMAX) mt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // three-beat transaction, back-to-back delivery from the cycle after DONE
        send(2'd1, 36'd1, 7'h01, 1, 1);
        send(2'd1, 36'd2, 7'h02, 1, 1);
        send(2'd2, 36'd3, 7'h03, 1, 1);
        chk("t1_vld0", out_vld, 1);
        tick(1);
        chk("t1_vld1", out_vld, 1);
        tick(1);
        chk("t1_vld2", out_vld, 1);
        tick(1);
        chk("t1_vld3", out_vld, 0);
        chk("t1_idle", idle, 1);

        // single-beat transaction
        send(2'd2, 36'h123456789, 7'h55, 1, 1);
        drain();

        // overflow: fifth beat finds the FIFO full, whole transaction dropped
        send(2'd1, 36'h11, 7'h11, 1, 0);
        send(2'd1, 36'h12, 7'h12, 1, 0);
        send(2'd1, 36'h13, 7'h13, 1, 0);
        send(2'd1, 36'h14, 7'h14, 1, 0);
        send(2'd2, 36'h15, 7'h15, 1, 0);
        tick(0);
        chk("t3_no_vld", out_vld, 0);
        send(2'd1, 36'h21, 7'h21, 1, 1);
        send(2'd2, 36'h22, 7'h22, 1, 1);
        drain();

        // beats with clk_en=0 are ignored whatever their type
        send(2'd1, 36'h31, 7'h31, 1, 1);
        send(2'd1, 36'hBAD, 7'h7f, 0, 1);
        send(2'd1, 36'h32, 7'h32, 1, 1);
        send(2'd2, 36'hBAD, 7'h7e, 0, 1);
        send(2'd3, 36'hBAD, 7'h7d, 0, 1);
        send(2'd2, 36'h33, 7'h33, 1, 1);
        drain();

        // illegal type mid-transaction discards it, then a lone DONE is delivered
        do_reset();
        send(2'd1, 36'h41, 7'h41, 1, 1);
        send(2'd1, 36'h42, 7'h42, 1, 1);
        send(2'd3, 36'h43, 7'h43, 1, 1);
        chk("t5_no_vld", out_vld, 0);
        chk("t5_cnt", drop_cnt, 1);
        send(2'd2, 36'h44, 7'h44, 1, 1);
        drain();

        // reset with a committed transaction pending discards it
        send(2'd1, 36'h51, 7'h51, 1, 0);
        send(2'd1, 36'h52, 7'h52, 1, 0);
        send(2'd2, 36'h53, 7'h53, 1, 0);
        chk("t6_pending", out_vld, 1);
        do_reset();
        repeat (4) tick(1);
        chk("t6_nothing", out_vld, 0);

        // drop counter saturates at all-ones
        for (int i = 0; i < 5; i++) begin
            send(2'd1, 36'(i), 7'h60, 1, 1);
            send(2'd3, 36'h0, 7'h0, 1, 1);
        end
        chk("t7_sat", drop_cnt, CMAX);

        // random traffic with random backpressure
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] t;
            r = $urandom_range(0, 19);
            t = (r < 11) ? 2'd1 : (r < 16) ? 2'd2 : (r < 19) ? 2'd0 : 2'd3;
            send(t, {$urandom, 4'($urandom)}, 7'($urandom), $urandom_range(0, 9) != 0,
                 1'($urandom));
        end
        send(2'd2, 36'hF00D, 7'h3c, 1, 1);
        drain();
`ifdef HERO_WRITE_RX_STATS_EN
        chk("txn_cnt", txn_cnt, mt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
